// File: rtl/spm_ex_loader.sv
// spm_ex_loader: block-transfer sequencer for the scratchpad external port.
// Accepts {direction, base, length} commands and issues one registered write
// or read strobe per handshake on ex_bus = {wen, ren, addr, data}, stepping
// through consecutive addresses that wrap modulo 2^A_W.
module spm_ex_loader #(
  parameter int A_W = 10,
  parameter int D_W = 32
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [A_W-1:0]     cmd_base,
  input  logic [A_W:0]       cmd_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [D_W-1:0]     s_data,
  input  logic               rd_ready,
  output logic [D_W+A_W+1:0] ex_bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Largest legal transfer (2^A_W words) and the counter increment.
  localparam logic [A_W:0] LEN_MAX = {1'b1, {A_W{1'b0}}};
  localparam logic [A_W:0] CNT_ONE = {{A_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [A_W-1:0]   base_q, base_d;
  logic [A_W:0]     len_q, len_d;
  logic [A_W:0]     cnt_q, cnt_d;
  logic             wen_q, wen_d;
  logic             ren_q, ren_d;
  logic [A_W-1:0]   addr_q, addr_d;
  logic [D_W-1:0]   data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cmd_fire;
  logic             wr_fire;
  logic             rd_fire;
  logic [A_W:0]     len_clamped;
  logic [A_W:0]     cnt_inc;
  logic             last_beat;
  logic [A_W-1:0]   strobe_addr;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign wr_fire     = s_valid && s_ready;
  assign rd_fire     = rd_ready && (state_q == ST_READ);
  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign cnt_inc     = cnt_q + CNT_ONE;
  assign last_beat   = (cnt_inc == len_q);
  // Truncation to A_W bits gives the required wrap from the top address to 0.
  assign strobe_addr = base_q + cnt_q[A_W-1:0];

  // State register.
  // NOTE: the reset branch is asynchronous, so a mid-transfer reset aborts
  // immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state decode. Direction is carried by the WRITE/READ state itself.
  always_comb begin
    // NOTE: default-assign first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (len_clamped == '0) state_d = ST_DONE;
          else if (cmd_write)    state_d = ST_WRITE;
          else                   state_d = ST_READ;
        end
      end
      ST_WRITE: if (wr_fire && last_beat) state_d = ST_DONE;
      ST_READ:  if (rd_fire && last_beat) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: handshake readies straight from state, the rest registered.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    s_ready   = (state_q == ST_WRITE);
    ex_bus    = {wen_q, ren_q, addr_q, data_q};
    busy      = busy_q;
    done      = done_q;
  end

  // Datapath next-state: command capture, strobe formation and word counting.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    wen_d  = 1'b0;
    ren_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          base_d = cmd_base;
          len_d  = len_clamped;
          cnt_d  = '0;
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          wen_d  = 1'b1;
          addr_d = strobe_addr;
          data_d = s_data;
          cnt_d  = cnt_inc;
        end
      end
      ST_READ: begin
        if (rd_fire) begin
          ren_d  = 1'b1;
          addr_d = strobe_addr;
          data_d = '0;
          cnt_d  = cnt_inc;
        end
      end
      default: ;
    endcase
    // busy/done are registered versions of where the FSM is heading.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Datapath and status registers; all clear to their idle values on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      wen_q  <= 1'b0;
      ren_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      ren_q  <= ren_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_spm_ex_loader.sv
// Testbench for spm_ex_loader: directed and randomized transfers checked
// cycle by cycle against a transfer-level expectation of strobe order,
// addresses, data, done timing and status flags.
module tb_spm_ex_loader;

  localparam int A_W = 10;
  localparam int D_W = 32;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [A_W-1:0]    cmd_base;
  logic [A_W:0]      cmd_len;
  logic              s_valid;
  logic              s_ready;
  logic [D_W-1:0]    s_data;
  logic              rd_ready;
  logic [D_W+A_W+1:0] ex_bus;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  // Reference view of the bus fields that hold between strobes.
  logic [A_W-1:0] exp_addr = '0;
  logic [D_W-1:0] exp_data = '0;

  // Handshake pattern to apply (empty: hold 1, or random when rand_mode).
  bit             pat_q[$];
  bit             rand_mode = 1'b0;
  logic [D_W-1:0] wq[$];

  spm_ex_loader #(.A_W(A_W), .D_W(D_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .rd_ready  (rd_ready),
    .ex_bus    (ex_bus),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit next_bit();
    if (pat_q.size() > 0) return pat_q.pop_front();
    if (rand_mode) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  function automatic logic [D_W+A_W+1:0] idle_bus();
    return {2'b00, exp_addr, exp_data};
  endfunction

  // One complete command from an idle DUT back to idle.
  task automatic run_xfer(input bit dir, input logic [A_W-1:0] base,
                          input logic [A_W:0] len_req, input string name);
    int len_eff;
    int acc;
    int k;
    int budget;
    bit v;
    logic [D_W-1:0] w;
    logic [D_W+A_W+1:0] exp_bus;

    len_eff = (int'(len_req) > 1024) ? 1024 : int'(len_req);
    budget  = 4 * len_eff + 64;

    check({name, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = dir;
    cmd_base  = base;
    cmd_len   = len_req;
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_base  = A_W'($urandom);
    cmd_len   = (A_W+1)'($urandom);
    check({name, " cmd_ready after accept"}, 64'(cmd_ready), 64'd0);
    check({name, " busy after accept"}, 64'(busy), 64'd1);
    check({name, " bus after accept"}, 64'(ex_bus), 64'(idle_bus()));

    if (len_eff == 0) begin
      check({name, " done len0"}, 64'(done), 64'd1);
    end else begin
      check({name, " done early"}, 64'(done), 64'd0);
      check({name, " s_ready in xfer"}, 64'(s_ready), 64'(dir));
      acc = 0;
      k   = 0;
      while (acc < len_eff && k < budget) begin
        v = next_bit();
        w = $urandom;
        if (dir && v && wq.size() > 0) w = wq.pop_front();
        if (dir) begin
          s_valid  = v;
          s_data   = w;
          rd_ready = 1'($urandom);
        end else begin
          rd_ready = v;
          s_valid  = 1'($urandom);
          s_data   = w;
        end
        step();
        if (v) begin
          exp_addr = A_W'(int'(base) + acc);
          exp_data = dir ? w : '0;
          acc++;
          exp_bus = {dir, ~dir, exp_addr, exp_data};
        end else begin
          exp_bus = idle_bus();
        end
        check({name, " bus"}, 64'(ex_bus), 64'(exp_bus));
        check({name, " done"}, 64'(done), 64'(acc == len_eff));
        check({name, " busy"}, 64'(busy), 64'd1);
        k++;
      end
      if (acc < len_eff) check({name, " beat budget expired"}, 64'(acc), 64'(len_eff));
    end

    // DONE cycle: offered words/reads must not be taken.
    s_valid  = 1'b1;
    rd_ready = 1'b1;
    check({name, " s_ready in done"}, 64'(s_ready), 64'd0);
    check({name, " cmd_ready in done"}, 64'(cmd_ready), 64'd0);
    step();
    check({name, " bus after done"}, 64'(ex_bus), 64'(idle_bus()));
    check({name, " done falls"}, 64'(done), 64'd0);
    check({name, " busy falls"}, 64'(busy), 64'd0);
    check({name, " cmd_ready rises"}, 64'(cmd_ready), 64'd1);
    s_valid  = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    rd_ready  = 1'b0;

    // Reset state, both while held and after release.
    repeat (3) @(posedge clk);
    #1;
    check("reset bus", 64'(ex_bus), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post-reset bus", 64'(ex_bus), 64'd0);
    check("post-reset busy", 64'(busy), 64'd0);
    check("post-reset cmd_ready", 64'(cmd_ready), 64'd1);

    // Full-rate load of A0..A3 at 0x010.
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_xfer(1'b1, 10'h010, 11'd4, "load4");

    // Stream backpressure across the address wrap.
    pat_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_xfer(1'b1, 10'h3FE, 11'd4, "wrap");

    // Read throttling.
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_xfer(1'b0, 10'h100, 11'd3, "read3");

    // Edge lengths.
    run_xfer(1'b1, 10'h055, 11'd0, "len0");
    run_xfer(1'b1, 10'h005, 11'd1024, "len1024");
    check("len1024 last addr", 64'(exp_addr), 64'h004);
    run_xfer(1'b0, 10'h005, 11'd1500, "len1500");
    check("len1500 last addr", 64'(exp_addr), 64'h004);

    // Mid-transfer reset with a command held pending.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_base  = 10'h200;
    cmd_len   = 11'd8;
    step();
    check("hold accept cmd_ready", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      logic [D_W-1:0] w;
      w = $urandom;
      s_valid = 1'b1;
      s_data  = w;
      step();
      exp_addr = A_W'(10'h200 + i);
      exp_data = w;
      check("hold bus", 64'(ex_bus), 64'({2'b10, exp_addr, exp_data}));
      check("hold cmd_ready", 64'(cmd_ready), 64'd0);
      check("hold busy", 64'(busy), 64'd1);
      check("hold done", 64'(done), 64'd0);
    end
    #2;
    rst = 1'b0;
    #1;
    check("midrst bus", 64'(ex_bus), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst s_ready", 64'(s_ready), 64'd0);
    cmd_valid = 1'b0;
    s_valid   = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("after midrst no done", 64'(done), 64'd0);
      check("after midrst idle", 64'(busy), 64'd0);
    end
    run_xfer(1'b1, 10'h020, 11'd2, "restart");

    // Randomized commands with random handshake gaps.
    rand_mode = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [A_W-1:0] b;
      logic [A_W:0]   l;
      bit             d;
      b = A_W'($urandom);
      l = (A_W+1)'($urandom_range(0, 40));
      d = 1'($urandom);
      run_xfer(d, b, l, "random");
    end
    rand_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
